match_sequencer: RTL
====================

# match_sequencer

Two-player match controller for the game logic. It sits between the PS/2 keycode path, the ball/paddle datapath and the VGA screen selection. It sequences start screen, pre-round countdown, live play, optional pause and win screens. It also keeps both players' scores and tells the datapath when to reset the ball and when to advance.

## Interface
Parameters:
- WIN_POINTS, 5, score that ends the match; legal range 1..15.
- TICKS_PER_SEC, 65_000_000, clk cycles per countdown step; must be ≥ 2.
- COUNTDOWN_SEC, 3, countdown steps before each round; legal range 1..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- keycode  in  16  last two PS/2 bytes; [15:8] previous byte, [7:0] latest byte.
- point_p1  in  1  one-cycle pulse: player 1 scored.
- point_p2  in  1  one-cycle pulse: player 2 scored.
- screen  out  2  screen select: 0 START, 1 GAME, 2 PLAYER_1 wins, 3 PLAYER_2 wins.
- game_run  out  1  high while the datapath may move ball and paddles.
- round_start  out  1  one-cycle pulse: datapath re-centres the ball.
- score_p1  out  4  player 1 score.
- score_p2  out  4  player 2 score.
- countdown  out  2  remaining countdown steps for on-screen display; 0 outside COUNTDOWN.

## Operation
- Key press event for code K: keycode differs from its previous-cycle value, keycode[15:8] != 8'hF0, and keycode[7:0] == K.
  - Break sequences are never events.
  - A held key repeating the identical keycode is not an event.
  - ENTER = 8'h5A, ESC = 8'h76.
- States: IDLE, COUNTDOWN, PLAY, PAUSE (only with macro), WIN.
- IDLE:
  - screen = 0.
  - ENTER → clear both scores, pulse round_start, load countdown = COUNTDOWN_SEC, go to COUNTDOWN.
- COUNTDOWN:
  - screen = 1, game_run = 0.
  - The tick counter counts 0..TICKS_PER_SEC-1. On wrap, countdown decrements.
  - When countdown decrements from 1 to 0, go to PLAY.
- PLAY:
  - screen = 1, game_run = 1.
  - point_p1 alone → score_p1 + 1. If the new value == WIN_POINTS, go to WIN with winner P1. Otherwise pulse round_start, reload countdown and go to COUNTDOWN.
  - point_p2 handled the same way for player 2.
  - point_p1 and point_p2 in the same cycle → no score change; pulse round_start and reload countdown (replayed round).
- WIN:
  - screen = 2 (P1) or 3 (P2), game_run = 0, scores held for display.
  - ENTER → clear scores, pulse round_start, go to COUNTDOWN (rematch).
- Point pulses outside PLAY are ignored.
- Scores saturate at 15 and never wrap.
- The tick counter is cleared on every entry to COUNTDOWN, so each countdown step is exactly TICKS_PER_SEC cycles.

## Timing
- All outputs are registered. Reset values:
  - screen = 0, game_run = 0, round_start = 0.
  - score_p1 = score_p2 = 0, countdown = 0.
  - State IDLE, tick counter 0.
- During rst the previous-keycode register loads the current keycode. No spurious event is generated after reset release.
- Event latency:
  - Keycode change is sampled at edge N.
  - State, screen, scores and round_start update at edge N+1.
  - round_start is high for exactly the one cycle after that edge.
- A point pulse at edge N changes the score and leaves PLAY at edge N+1. game_run drops in the same cycle.
- COUNTDOWN duration from entry to PLAY: COUNTDOWN_SEC × TICKS_PER_SEC cycles. game_run rises on the cycle countdown reaches 0.
- rst mid-match overrides everything: outputs return to reset values on the next edge.

## Configuration
- PAUSE_EN defined:
  - ESC in PLAY → PAUSE (screen = 1, game_run = 0, scores and countdown frozen, point pulses ignored).
  - ESC in PAUSE → PLAY, with no countdown.
  - ESC in other states is ignored.
- PAUSE_EN undefined: no PAUSE state, and ESC is ignored everywhere.

## Test plan
Run with TICKS_PER_SEC=4, COUNTDOWN_SEC=3, WIN_POINTS=2.
- Reset with keycode=16'h005A held, no change → stays IDLE, screen=0, no round_start.
- Keycode 16'h0000→16'h005A → one round_start pulse. countdown shows 3,2,1 for 4 cycles each, then game_run=1 exactly 12 cycles after entry. Then keycode 16'h005A→16'hF05A → no event.
- In PLAY, point_p1 twice (each followed by the full countdown) → score_p1=1 after the first, then screen=2, game_run=0, score_p1=2.
- In PLAY, point_p1 and point_p2 in the same cycle → scores unchanged, round_start pulse, countdown=3.
- In WIN, ENTER event → scores clear to 0, round_start pulse, COUNTDOWN. Assert rst mid-countdown → all outputs at reset values next cycle.
- PAUSE_EN build: ESC in PLAY → game_run=0, point_p2 ignored. ESC again → game_run=1 with no countdown. Non-PAUSE_EN build: ESC has no effect.

Source files
------------

// File: rtl/match_sequencer.sv
// Two-player match controller: start screen, countdown, play, win, score keeping.
// Optional PAUSE state (ESC toggles PLAY/PAUSE) is built only when PAUSE_EN is defined.
module match_sequencer #(
    parameter int WIN_POINTS    = 5,
    parameter int TICKS_PER_SEC = 65_000_000,
    parameter int COUNTDOWN_SEC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        point_p1,
    input  logic        point_p2,
    output logic [1:0]  screen,
    output logic        game_run,
    output logic        round_start,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic [1:0]  countdown
);

    localparam int              TW        = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0]   TICK_MAX  = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      WIN_SCORE = 4'(WIN_POINTS);
    localparam logic [1:0]      CD_LOAD   = 2'(COUNTDOWN_SEC);
    localparam logic [7:0]      KEY_ENTER = 8'h5A;
    localparam logic [7:0]      KEY_BREAK = 8'hF0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd4;
`ifdef PAUSE_EN
    localparam logic [7:0] KEY_ESC  = 8'h76;
    localparam logic [2:0] ST_PAUSE = 3'd3;
`endif

    logic [2:0]       state_reg, state_next;
    logic [TW-1:0]    tick_reg, tick_next;
    logic [1:0]       cd_reg, cd_next;
    logic [1:0][3:0]  score_reg, score_next, score_inc;
    logic             winner_reg, winner_next;
    logic [15:0]      key_reg, key_prev_reg;
    logic [1:0]       point_reg;
    logic [1:0]       screen_reg, screen_next;
    logic             run_reg, run_next;
    logic             rs_reg, rs_next;
    logic             key_new, enter_evt;
    logic [1:0]       point_in;

    assign point_in = {point_p2, point_p1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            // Point pulses are registered so they line up with the keycode event path.
            always_ff @(posedge clk) begin
                if (rst)
                    point_reg[gi] <= 1'b0;
                else
                    point_reg[gi] <= point_in[gi];
            end
            assign score_inc[gi] = (score_reg[gi] == 4'd15) ? 4'd15 : score_reg[gi] + 4'd1;
        end
    endgenerate

    // A new code that is not a break byte; held-key repeats compare equal and are dropped.
    assign key_new   = (key_reg != key_prev_reg) && (key_reg[15:8] != KEY_BREAK);
    assign enter_evt = key_new && (key_reg[7:0] == KEY_ENTER);
`ifdef PAUSE_EN
    logic esc_evt;
    assign esc_evt   = key_new && (key_reg[7:0] == KEY_ESC);
`endif

    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        cd_next     = cd_reg;
        score_next  = score_reg;
        winner_next = winner_reg;
        rs_next     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_WIN: begin
                if (enter_evt) begin
                    score_next = '0;
                    rs_next    = 1'b1;
                    cd_next    = CD_LOAD;
                    tick_next  = '0;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (tick_reg == TICK_MAX) begin
                    tick_next = '0;
                    if (cd_reg <= 2'd1) begin
                        cd_next    = 2'd0;
                        state_next = ST_PLAY;
                    end else begin
                        cd_next = cd_reg - 2'd1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            ST_PLAY: begin
                if (point_reg != 2'b00) begin
                    rs_next    = 1'b1;
                    cd_next    = CD_LOAD;
                    tick_next  = '0;
                    state_next = ST_COUNT;
                    // A simultaneous point from both players replays the round unscored.
                    if (point_reg == 2'b01) begin
                        score_next[0] = score_inc[0];
                        if (score_inc[0] == WIN_SCORE) begin
                            rs_next     = 1'b0;
                            cd_next     = 2'd0;
                            winner_next = 1'b0;
                            state_next  = ST_WIN;
                        end
                    end else if (point_reg == 2'b10) begin
                        score_next[1] = score_inc[1];
                        if (score_inc[1] == WIN_SCORE) begin
                            rs_next     = 1'b0;
                            cd_next     = 2'd0;
                            winner_next = 1'b1;
                            state_next  = ST_WIN;
                        end
                    end
                end
`ifdef PAUSE_EN
                else if (esc_evt) begin
                    state_next = ST_PAUSE;
                end
`endif
            end
`ifdef PAUSE_EN
            ST_PAUSE: begin
                if (esc_evt)
                    state_next = ST_PLAY;
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        screen_next = 2'd1;
        if (state_next == ST_IDLE)
            screen_next = 2'd0;
        else if (state_next == ST_WIN)
            screen_next = winner_next ? 2'd3 : 2'd2;
        run_next = (state_next == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tick_reg     <= '0;
            cd_reg       <= 2'd0;
            score_reg    <= '0;
            winner_reg   <= 1'b0;
            screen_reg   <= 2'd0;
            run_reg      <= 1'b0;
            rs_reg       <= 1'b0;
            key_reg      <= keycode;
            key_prev_reg <= keycode;
        end else begin
            state_reg    <= state_next;
            tick_reg     <= tick_next;
            cd_reg       <= cd_next;
            score_reg    <= score_next;
            winner_reg   <= winner_next;
            screen_reg   <= screen_next;
            run_reg      <= run_next;
            rs_reg       <= rs_next;
            key_reg      <= keycode;
            key_prev_reg <= key_reg;
        end
    end

    assign screen      = screen_reg;
    assign game_run    = run_reg;
    assign round_start = rs_reg;
    assign score_p1    = score_reg[0];
    assign score_p2    = score_reg[1];
    assign countdown   = cd_reg;

endmodule
